mux_rr_arbiter: RTL

Two-requester round-robin arbiter sharing a single registered output channel between input channels A and B. It generates the 2:1 select for the shared datapath and locks the grant for a whole packet, delimited by `last`. It uses valid/ready handshakes on all channels, with one register stage on the output. It sits in front of any single-consumer resource fed by two producers.

---
 rtl/mux_arb_pkg.sv | 9 +
 rtl/mux_2to1_w.sv | 15 +
 rtl/mux_rr_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and source encodings for the two-input round-robin packet arbiter.
package mux_arb_pkg;

    typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} arb_state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/mux_2to1_w.sv
// 2:1 selector for a payload bundled with its last flag ({last, data}).
module mux_2to1_w
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             sel,
    input  logic [WIDTH:0]   in0,
    input  logic [WIDTH:0]   in1,
    output logic [WIDTH:0]   out
);

    assign out = (sel == SRC_B) ? in1 : in0;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter granting one of two packet streams to a single registered output;
// the grant is held from the first beat of a packet until its last beat is accepted.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [WIDTH-1:0] y_data,
    output logic             y_last,
    output logic             y_src
);

    arb_state_t       state;
    arb_state_t       state_next;
    logic             prio;
    logic             prio_next;
    logic             sel;
    logic             sel_prev;
    logic             space;
    logic             accept;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH:0]   mux_out;

    assign space = !y_valid || y_ready;

    mux_2to1_w #(.WIDTH(WIDTH)) u_mux (
        .sel (sel),
        .in0 ({a_last, a_data}),
        .in1 ({b_last, b_data}),
        .out (mux_out)
    );

    assign sel_last = mux_out[WIDTH];
    assign sel_data = mux_out[WIDTH-1:0];
    assign accept   = (sel == SRC_A) ? (a_valid && a_ready) : (b_valid && b_ready);

    // State register; sel_prev lets an idle arbiter keep pointing at the last source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            prio     <= SRC_A;
            sel_prev <= SRC_A;
        end else begin
            state    <= state_next;
            prio     <= prio_next;
            sel_prev <= sel;
        end
    end

    always_comb begin
        state_next = state;
        prio_next  = prio;
        if (accept) begin
            if (sel_last) begin
                state_next = IDLE;
                prio_next  = ~sel;
            end else begin
                state_next = (sel == SRC_A) ? LOCK_A : LOCK_B;
            end
        end
    end

    // Grant and ready generation: an idle arbiter only readies a source that is requesting.
    always_comb begin
        sel     = sel_prev;
        a_ready = 1'b0;
        b_ready = 1'b0;
        case (state)
            LOCK_A:  sel = SRC_A;
            LOCK_B:  sel = SRC_B;
            default: begin
                if (a_valid && b_valid) sel = prio;
                else if (a_valid)       sel = SRC_A;
                else if (b_valid)       sel = SRC_B;
            end
        endcase
        if (sel == SRC_A) a_ready = space && ((state != IDLE) || a_valid);
        else              b_ready = space && ((state != IDLE) || b_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid <= 1'b0;
            y_data  <= '0;
            y_last  <= 1'b0;
            y_src   <= SRC_A;
        end else if (accept) begin
            y_valid <= 1'b1;
            y_data  <= sel_data;
            y_last  <= sel_last;
            y_src   <= sel;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

endmodule
